// File: rtl/fsub_norm_arb.sv
// Round-robin arbiter for the sin and cos requesters, feeding a shared two-stage LZD and normalize pipeline.
// Optional FSUB_NORM_ARB_STAT_EN adds saturating stall and grant counters.
module fsub_norm_arb #(
  parameter int EXP_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [33:0]      i_req0_mant,
  input  logic [EXP_W-1:0] i_req0_exp,
  input  logic             i_req0_sign,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [33:0]      i_req1_mant,
  input  logic [EXP_W-1:0] i_req1_exp,
  input  logic             i_req1_sign,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_tag,
  output logic [33:0]      o_mant,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_sign,
  output logic             o_zero,
  output logic             o_uf,
  output logic             o_ov
`ifdef FSUB_NORM_ARB_STAT_EN
  ,
  output logic [15:0]      o_stall_cnt,
  output logic [15:0]      o_grant1_cnt
`endif
);

  localparam int E2 = EXP_W + 2;
  localparam logic [E2-1:0] EMAX = {2'b00, {EXP_W{1'b1}}};

  typedef struct packed {
    logic             tag;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [33:0]      mant;
  } op_t;

  logic last;
  logic grant0;
  logic grant1;
  logic s1_adv;
  logic s2_adv;
  logic hs0;
  logic hs1;
  logic s1_v;
  op_t  s1_op;
  op_t  sel;

  // On a tie the requester that was not granted last wins
  always_comb begin
    grant0 = i_req0_valid & (~i_req1_valid | last);
    grant1 = i_req1_valid & ~grant0;
    s2_adv = ~o_valid | i_ready;
    s1_adv = ~s1_v | s2_adv;
    o_req0_ready = grant0 & s1_adv & ~i_rst;
    o_req1_ready = grant1 & s1_adv & ~i_rst;
    hs0 = o_req0_ready & i_req0_valid;
    hs1 = o_req1_ready & i_req1_valid;
  end

  always_comb begin
    sel.tag  = grant1;
    sel.sign = grant1 ? i_req1_sign : i_req0_sign;
    sel.exp  = grant1 ? i_req1_exp : i_req0_exp;
    sel.mant = grant1 ? i_req1_mant : i_req0_mant;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last  <= 1'b1;
      s1_v  <= 1'b0;
      s1_op <= '0;
    end else begin
      if (s1_adv) begin
        s1_v <= hs0 | hs1;
        if (hs0 | hs1)
          s1_op <= sel;
      end
      if (hs0 | hs1)
        last <= hs1;
    end
  end

  logic [5:0]       lzd;
  logic [33:0]      shifted;
  logic [E2-1:0]    e_raw;
  logic             is_zero;
  logic             is_uf;
  logic             is_ov;
  logic [33:0]      n_mant;
  logic [EXP_W-1:0] n_exp;

  always_comb begin
    lzd = 6'd33;
    if (s1_op.mant[33])
      lzd = 6'd0;
    else if (s1_op.mant[32])
      lzd = 6'd1;
    else
      // ascending scan: the highest set bit assigns last
      for (int i = 0; i < 32; i++)
        if (s1_op.mant[i])
          lzd = 6'(33 - i);
    shifted = s1_op.mant << lzd;
    e_raw   = {2'b00, s1_op.exp} + E2'(1) - E2'(lzd);
    is_zero = (s1_op.mant == '0);
    is_uf   = ~is_zero & (e_raw[E2-1] | (e_raw == '0));
    is_ov   = ~is_zero & ~is_uf & (e_raw >= EMAX);
    n_mant  = shifted;
    n_exp   = e_raw[EXP_W-1:0];
    if (is_zero | is_uf) begin
      n_mant = '0;
      n_exp  = '0;
    end else if (is_ov) begin
      n_mant = '0;
      n_exp  = '1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_tag   <= 1'b0;
      o_mant  <= '0;
      o_exp   <= '0;
      o_sign  <= 1'b0;
      o_zero  <= 1'b0;
      o_uf    <= 1'b0;
      o_ov    <= 1'b0;
    end else if (s2_adv) begin
      o_valid <= s1_v;
      if (s1_v) begin
        o_tag  <= s1_op.tag;
        o_mant <= n_mant;
        o_exp  <= n_exp;
        o_sign <= s1_op.sign;
        o_zero <= is_zero;
        o_uf   <= is_uf;
        o_ov   <= is_ov;
      end
    end
  end

`ifdef FSUB_NORM_ARB_STAT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt  <= '0;
      o_grant1_cnt <= '0;
    end else begin
      if (o_valid & ~i_ready & (o_stall_cnt != 16'hFFFF))
        o_stall_cnt <= o_stall_cnt + 16'd1;
      if (hs1 & (o_grant1_cnt != 16'hFFFF))
        o_grant1_cnt <= o_grant1_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fsub_norm_arb.sv
// Bench for fsub_norm_arb: directed plan steps, then random traffic
// scored against a transaction-level model of arbitration and normalization.
module tb_fsub_norm_arb;

  localparam int EXP_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [33:0] req0_mant, req1_mant;
  logic [7:0]  req0_exp, req1_exp;
  logic        req0_sign, req1_sign;
  logic        out_valid, dn_ready;
  logic        out_tag, out_sign, out_zero, out_uf, out_ov;
  logic [33:0] out_mant;
  logic [7:0]  out_exp;
`ifdef FSUB_NORM_ARB_STAT_EN
  logic [15:0] stall_cnt, grant1_cnt;
`endif

  always #5 clk = ~clk;

  fsub_norm_arb #(.EXP_W(EXP_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_mant(req0_mant), .i_req0_exp(req0_exp), .i_req0_sign(req0_sign),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_mant(req1_mant), .i_req1_exp(req1_exp), .i_req1_sign(req1_sign),
    .o_valid(out_valid), .i_ready(dn_ready), .o_tag(out_tag),
    .o_mant(out_mant), .o_exp(out_exp), .o_sign(out_sign),
    .o_zero(out_zero), .o_uf(out_uf), .o_ov(out_ov)
`ifdef FSUB_NORM_ARB_STAT_EN
    , .o_stall_cnt(stall_cnt), .o_grant1_cnt(grant1_cnt)
`endif
  );

  typedef struct {
    logic       tag;
    logic       sign;
    logic [7:0] exp;
    logic [33:0] mant;
  } item_t;

  int npass = 0;
  int nfail = 0;
  int total = 0;

  logic  mlast;
  logic  ms1_v, ms2_v;
  item_t ms1, ms2;
  logic  hs0, hs1, hs_tag;

  logic [46:0] obs;
  assign obs = {out_tag, out_sign, out_zero, out_uf, out_ov, out_exp, out_mant};

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    total++;
    assert (got === want) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Expected result from the leading-one position, in plain integers
  function automatic logic [46:0] ref_out(item_t it);
    int p;
    int lz;
    int e;
    logic [33:0] m;
    logic [7:0] ex;
    logic z, u, o;
    p = -1;
    z = 0; u = 0; o = 0;
    for (int b = 0; b < 34; b++)
      if (it.mant[b]) p = b;
    if (p < 0) begin
      z = 1; m = '0; ex = '0;
    end else begin
      lz = 33 - p;
      m = it.mant << lz;
      e = int'(it.exp) + 1 - lz;
      if (e <= 0) begin
        u = 1; m = '0; ex = '0;
      end else if (e >= (1 << EXP_W) - 1) begin
        o = 1; m = '0; ex = '1;
      end else begin
        ex = e[7:0];
      end
    end
    return {it.tag, it.sign, z, u, o, ex, m};
  endfunction

  function automatic logic [33:0] rand_mant();
    logic [63:0] r;
    int k;
    r = {$urandom, $urandom};
    k = $urandom_range(0, 35);
    if (k == 35) return '0;
    if (k == 34) return r[33:0];
    return r[33:0] >> k;
  endfunction

  task automatic arm(bit id);
    if (id == 0 && !req0_valid) begin
      req0_valid = 1; req0_mant = rand_mant();
      req0_exp = 8'($urandom); req0_sign = 1'($urandom);
    end
    if (id == 1 && !req1_valid) begin
      req1_valid = 1; req1_mant = rand_mant();
      req1_exp = 8'($urandom); req1_sign = 1'($urandom);
    end
  endtask

  // One clock: check against the model, advance it, then retire handshaken requests
  task automatic cycle();
    logic s1a, s2a, g0, g1, r0, r1;
    item_t ni;
    #1;
    s2a = !ms2_v || dn_ready;
    s1a = !ms1_v || s2a;
    g0 = req0_valid && (!req1_valid || mlast);
    g1 = req1_valid && !g0;
    r0 = g0 && s1a && !rst;
    r1 = g1 && s1a && !rst;
    chk("ready0", req0_ready, r0);
    chk("ready1", req1_ready, r1);
    chk("valid", out_valid, ms2_v);
    if (ms2_v) chk("out", obs, ref_out(ms2));
    hs0 = r0; hs1 = r1; hs_tag = r1;
    ni.tag  = r1;
    ni.sign = r1 ? req1_sign : req0_sign;
    ni.exp  = r1 ? req1_exp : req0_exp;
    ni.mant = r1 ? req1_mant : req0_mant;
    @(posedge clk);
    if (rst) begin
      ms1_v = 0; ms2_v = 0; mlast = 1;
    end else begin
      if (s2a) begin ms2_v = ms1_v; ms2 = ms1; end
      if (s1a) begin ms1_v = r0 || r1; ms1 = ni; end
      if (r0 || r1) mlast = r1;
    end
    @(negedge clk);
    if (r0) req0_valid = 0;
    if (r1) req1_valid = 0;
  endtask

  task automatic one(bit id, logic [33:0] m, logic [7:0] e);
    if (id == 0) begin
      req0_valid = 1; req0_mant = m; req0_exp = e; req0_sign = 1;
    end else begin
      req1_valid = 1; req1_mant = m; req1_exp = e; req1_sign = 0;
    end
    cycle();
    chk("one_hs", {hs1, hs0}, id ? 2'b10 : 2'b01);
    cycle();
    chk("one_latency", out_valid, 1'b1);
  endtask

  task automatic drain();
    req0_valid = 0; req1_valid = 0; dn_ready = 1;
    repeat (3) cycle();
  endtask

  initial begin
    logic prev;
    int acc;
    logic [46:0] held;
    rst = 1; dn_ready = 1;
    req0_valid = 0; req1_valid = 0;
    req0_mant = 0; req1_mant = 0; req0_exp = 0; req1_exp = 0;
    req0_sign = 0; req1_sign = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_out", obs, 47'd0);
    rst = 0; mlast = 1; ms1_v = 0; ms2_v = 0;

    one(0, 34'h0_8000_0000, 8'd100);
    chk("single", {out_tag, out_mant, out_exp}, {1'b0, 34'h2_0000_0000, 8'd99});
    cycle();
    one(1, 34'h2_0000_0001, 8'd254);
    chk("ovf", {out_tag, out_ov, out_exp, out_mant}, {1'b1, 1'b1, 8'hFF, 34'h0});
    cycle();
    one(0, 34'h2_0000_0001, 8'd50);
    chk("carry", {out_ov, out_exp, out_mant}, {1'b0, 8'd51, 34'h2_0000_0001});
    cycle();
    one(1, 34'h0, 8'd77);
    chk("zero", {out_zero, out_uf, out_exp, out_mant}, {1'b1, 1'b0, 8'd0, 34'h0});
    cycle();
    one(0, 34'h1, 8'd10);
    chk("uflow", {out_zero, out_uf, out_exp, out_mant}, {1'b0, 1'b1, 8'd0, 34'h0});
    drain();

    prev = 0;
    for (int i = 0; i < 8; i++) begin
      arm(0); arm(1);
      cycle();
      chk("cont_hs", hs0 | hs1, 1'b1);
      if (i > 0) chk("cont_alt", hs_tag, !prev);
      if (i > 1) chk("cont_thru", out_valid, 1'b1);
      prev = hs_tag;
    end
    drain();

    dn_ready = 0; acc = 0; held = '0;
    for (int i = 0; i < 5; i++) begin
      arm(0); arm(1);
      cycle();
      acc += int'(hs0) + int'(hs1);
      if (i == 1) held = obs;
      if (i > 1) chk("bp_hold", obs, held);
    end
    chk("bp_acc", acc, 2);
    dn_ready = 1;
    for (int i = 0; i < 8; i++) cycle();
    chk("bp_empty", out_valid, 1'b0);

    dn_ready = 0;
    arm(0); arm(1); cycle();
    arm(0); arm(1); cycle();
    chk("mid_full", out_valid, 1'b1);
    rst = 1;
    cycle();
    chk("mid_rst", out_valid, 1'b0);
    rst = 0; dn_ready = 1;
    arm(0); arm(1);
    cycle();
    chk("mid_tie", {hs1, hs0}, 2'b01);
    drain();

    for (int i = 0; i < 3000; i++) begin
      dn_ready = ($urandom_range(99) < 70);
      rst = ($urandom_range(999) < 5);
      if ($urandom_range(99) < 60) arm(0);
      if ($urandom_range(99) < 60) arm(1);
      cycle();
    end
    rst = 0;
    drain();
    drain();
    chk("final_empty", out_valid, 1'b0);

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
